mac_pe_dual: RTL and testbench

Parametrised weight-buffered multiply-accumulate processing element for the systolic MAC array. It is the successor to the single-mode weight-stationary PE and adds a double-buffered weight (shadow/active), a selectable output-stationary accumulate mode with drain, optional saturation, and sticky error flags. Each instance sits at one array grid point:
- ifmap flows east.
- Weights and partial sums flow south.

---
 rtl/mac_pe_dual.sv | 196 +++++++++++++++++++
 tb/tb_mac_pe_dual.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_dual.sv
// mac_pe_dual: weight-buffered MAC processing element for the systolic array.
// ifmap flows east and weights/psums flow south. The weight is double-buffered
// (shadow/active). The PE runs either as a weight-stationary systolic cell or as
// an output-stationary accumulator with drain. Saturation is optional, and the
// saturation and collision flags are sticky.
module mac_pe_dual #(
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32,
  parameter int SATURATE       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode_in,
  input  logic                      w_load_in,
  input  logic                      w_swap_in,
  input  logic [W_BITWIDTH-1:0]     w_data_in,
  output logic [W_BITWIDTH-1:0]     w_data_out,
  input  logic                      ifmap_valid_in,
  input  logic [IFMAP_BITWIDTH-1:0] ifmap_data_in,
  output logic                      ifmap_valid_out,
  output logic [IFMAP_BITWIDTH-1:0] ifmap_data_out,
  input  logic                      psum_valid_in,
  input  logic [OFMAP_BITWIDTH-1:0] psum_data_in,
  input  logic                      drain_in,
  output logic                      psum_valid_out,
  output logic [OFMAP_BITWIDTH-1:0] psum_data_out,
  output logic                      sat_flag,
  output logic                      collision_flag
);

  localparam int PW = IFMAP_BITWIDTH + W_BITWIDTH;
  localparam int OW = OFMAP_BITWIDTH;

  localparam logic [OW-1:0] MAX_VAL = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MIN_VAL = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    SYS = 2'd0,
    ACC = 2'd1,
    DRN = 2'd2
  } state_t;

  state_t state, next_state;

  logic signed [W_BITWIDTH-1:0]     shadow, active;
  logic signed [IFMAP_BITWIDTH-1:0] ifmap_q;
  logic                             ifmap_valid_q;
  logic        [OW-1:0]             acc;
  logic        [OW-1:0]             psum_data_q;
  logic                             psum_valid_q;
  logic                             mode_q;
  logic                             sat_q, coll_q;

  logic signed [PW-1:0] prod_full;
  logic signed [OW-1:0] prod_ext;
  logic                 mode_change;

  logic [OW:0] sys_sum, acc_sum, drn_sum;

  logic [OW-1:0] acc_d, psum_data_d;
  logic          psum_valid_d, sat_set, coll_set;

  // Adds at OW+1 bits. The result is {overflow, clamped-or-wrapped value}.
  function automatic logic [OW:0] add_sat(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [OW:0]   s;
    logic          ovf;
    logic [OW-1:0] res;
    s   = {a[OW-1], a} + {b[OW-1], b};
    ovf = s[OW] ^ s[OW-1];
    res = s[OW-1:0];
    if (ovf && (SATURATE != 0)) res = s[OW] ? MIN_VAL : MAX_VAL;
    return {ovf, res};
  endfunction

  assign prod_full   = active * ifmap_q;
  assign prod_ext    = OW'(prod_full);
  assign mode_change = (mode_in != mode_q);

  // Candidate sums for each datapath use.
  always_comb begin
    sys_sum = add_sat(prod_ext, psum_data_in);
    acc_sum = add_sat(acc, prod_ext);
    drn_sum = add_sat(acc, ifmap_valid_q ? prod_ext : '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SYS;
    else     state <= next_state;
  end

  // Next-state logic. A mode change re-enters the plain state for the new mode.
  // DRN behaves like ACC, so a back-to-back drain stays in DRN.
  always_comb begin
    next_state = state;
    if (mode_change) begin
      next_state = mode_in ? ACC : SYS;
    end else begin
      case (state)
        SYS:      next_state = SYS;
        ACC, DRN: next_state = drain_in ? DRN : ACC;
        default:  next_state = SYS;
      endcase
    end
  end

  // Output/datapath logic: next accumulator, psum output and flag set events.
  always_comb begin
    acc_d        = acc;
    psum_data_d  = psum_data_q;
    psum_valid_d = 1'b0;
    sat_set      = 1'b0;
    coll_set     = 1'b0;
    case (state)
      SYS: begin
        if (ifmap_valid_q && psum_valid_in) begin
          psum_data_d  = sys_sum[OW-1:0];
          psum_valid_d = 1'b1;
          sat_set      = sys_sum[OW];
        end
      end
      ACC, DRN: begin
        if (!mode_change && drain_in) begin
          // The local drain wins over any upstream psum arriving in the same cycle.
          psum_data_d  = drn_sum[OW-1:0];
          psum_valid_d = 1'b1;
          sat_set      = drn_sum[OW];
          coll_set     = psum_valid_in;
          acc_d        = '0;
        end else begin
          if (!mode_change && ifmap_valid_q) begin
            acc_d   = acc_sum[OW-1:0];
            sat_set = acc_sum[OW];
          end
          if (psum_valid_in) begin
            psum_data_d  = psum_data_in;
            psum_valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (mode_change) acc_d = '0;
  end

  // Weight buffers: the swap copies the old shadow while a load refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (w_load_in) shadow <= w_data_in;
      if (w_swap_in) active <= shadow;
    end
  end

  // ifmap pipeline register and mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifmap_q       <= '0;
      ifmap_valid_q <= 1'b0;
      mode_q        <= 1'b0;
    end else begin
      if (ifmap_valid_in) ifmap_q <= ifmap_data_in;
      ifmap_valid_q <= ifmap_valid_in;
      mode_q        <= mode_in;
    end
  end

  // Accumulator, psum output register and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      psum_data_q  <= '0;
      psum_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      coll_q       <= 1'b0;
    end else begin
      acc          <= acc_d;
      psum_data_q  <= psum_data_d;
      psum_valid_q <= psum_valid_d;
      if (sat_set)  sat_q  <= 1'b1;
      if (coll_set) coll_q <= 1'b1;
    end
  end

  assign w_data_out      = shadow;
  assign ifmap_data_out  = ifmap_q;
  assign ifmap_valid_out = ifmap_valid_q;
  assign psum_data_out   = psum_data_q;
  assign psum_valid_out  = psum_valid_q;
  assign sat_flag        = sat_q;
  assign collision_flag  = coll_q;

endmodule

// File: tb/tb_mac_pe_dual.sv
// Directed testbench for mac_pe_dual. A saturating instance and a wrapping
// instance share the same stimulus.
module tb_mac_pe_dual;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_in;
  logic        w_load_in, w_swap_in;
  logic [7:0]  w_data_in;
  logic        ifmap_valid_in;
  logic [15:0] ifmap_data_in;
  logic        psum_valid_in;
  logic [31:0] psum_data_in;
  logic        drain_in;

  logic [7:0]  w_data_out, w_data_out_w;
  logic        ifmap_valid_out, ifmap_valid_out_w;
  logic [15:0] ifmap_data_out, ifmap_data_out_w;
  logic        psum_valid_out, psum_valid_out_w;
  logic [31:0] psum_data_out, psum_data_out_w;
  logic        sat_flag, sat_flag_w;
  logic        collision_flag, collision_flag_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_pe_dual #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .mode_in(mode_in), .w_load_in(w_load_in), .w_swap_in(w_swap_in),
    .w_data_in(w_data_in), .w_data_out(w_data_out), .ifmap_valid_in(ifmap_valid_in),
    .ifmap_data_in(ifmap_data_in), .ifmap_valid_out(ifmap_valid_out),
    .ifmap_data_out(ifmap_data_out), .psum_valid_in(psum_valid_in), .psum_data_in(psum_data_in),
    .drain_in(drain_in), .psum_valid_out(psum_valid_out), .psum_data_out(psum_data_out),
    .sat_flag(sat_flag), .collision_flag(collision_flag)
  );

  mac_pe_dual #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .mode_in(mode_in), .w_load_in(w_load_in), .w_swap_in(w_swap_in),
    .w_data_in(w_data_in), .w_data_out(w_data_out_w), .ifmap_valid_in(ifmap_valid_in),
    .ifmap_data_in(ifmap_data_in), .ifmap_valid_out(ifmap_valid_out_w),
    .ifmap_data_out(ifmap_data_out_w), .psum_valid_in(psum_valid_in), .psum_data_in(psum_data_in),
    .drain_in(drain_in), .psum_valid_out(psum_valid_out_w), .psum_data_out(psum_data_out_w),
    .sat_flag(sat_flag_w), .collision_flag(collision_flag_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    w_load_in = 0; w_swap_in = 0; w_data_in = '0;
    ifmap_valid_in = 0; ifmap_data_in = '0;
    psum_valid_in = 0; psum_data_in = '0; drain_in = 0;
  endtask

  task automatic do_reset();
    rst = 1; mode_in = 0; clear_inputs();
    tick(); tick();
    rst = 0;
  endtask

  task automatic load_weight(input logic [7:0] w);
    w_load_in = 1; w_data_in = w; tick();
    w_load_in = 0; w_swap_in = 1; tick();
    w_swap_in = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (w_data_out !== 8'd0) begin n_fail++; $display("FAIL reset_w_data_out got %0h want 0", w_data_out); end
    n_checks++; if (ifmap_data_out !== 16'd0 || ifmap_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_ifmap got %0h/%0b want 0/0", ifmap_data_out, ifmap_valid_out); end
    n_checks++; if (psum_data_out !== 32'd0 || psum_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_psum got %0h/%0b want 0/0", psum_data_out, psum_valid_out); end
    n_checks++; if (sat_flag !== 1'b0 || collision_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %0b/%0b want 0/0", sat_flag, collision_flag); end
    n_checks++; if (sat_flag_w !== 1'b0 || collision_flag_w !== 1'b0 || w_data_out_w !== 8'd0) begin n_fail++; $display("FAIL reset_wrap_inst got %0b/%0b/%0h want 0/0/0", sat_flag_w, collision_flag_w, w_data_out_w); end
  endtask

  task automatic test_sys_mac();
    do_reset();
    w_load_in = 1; w_data_in = 8'd3; tick();
    n_checks++; if (w_data_out !== 8'd3) begin n_fail++; $display("FAIL sys_w_data_out got %0d want 3", w_data_out); end
    w_load_in = 0; w_swap_in = 1; tick();
    w_swap_in = 0;
    ifmap_valid_in = 1; ifmap_data_in = 16'd5; tick();
    n_checks++; if (ifmap_data_out !== 16'd5 || ifmap_valid_out !== 1'b1) begin n_fail++; $display("FAIL sys_ifmap_out got %0d/%0b want 5/1", ifmap_data_out, ifmap_valid_out); end
    ifmap_valid_in = 0; psum_valid_in = 1; psum_data_in = 32'd100; tick();
    n_checks++; if (psum_data_out !== 32'd115 || psum_valid_out !== 1'b1) begin n_fail++; $display("FAIL sys_mac got %0d/%0b want 115/1", $signed(psum_data_out), psum_valid_out); end
    psum_valid_in = 0; tick();
    n_checks++; if (psum_valid_out !== 1'b0) begin n_fail++; $display("FAIL sys_pulse got %0b want 0", psum_valid_out); end
    drain_in = 1; tick();
    drain_in = 0;
    n_checks++; if (psum_valid_out !== 1'b0) begin n_fail++; $display("FAIL sys_drain_ignored got %0b want 0", psum_valid_out); end
  endtask

  task automatic test_double_buffer();
    do_reset();
    load_weight(8'd2);
    w_load_in = 1; w_data_in = 8'd7; tick();
    w_load_in = 0;
    n_checks++; if (w_data_out !== 8'd7) begin n_fail++; $display("FAIL dbuf_w_data_out got %0d want 7", w_data_out); end
    ifmap_valid_in = 1; ifmap_data_in = 16'd4; psum_valid_in = 1; psum_data_in = 32'd0;
    tick(); tick();
    n_checks++; if (psum_data_out !== 32'd8 || psum_valid_out !== 1'b1) begin n_fail++; $display("FAIL dbuf_before_swap got %0d/%0b want 8/1", $signed(psum_data_out), psum_valid_out); end
    w_swap_in = 1; tick();
    w_swap_in = 0;
    n_checks++; if (psum_data_out !== 32'd8) begin n_fail++; $display("FAIL dbuf_swap_edge got %0d want 8", $signed(psum_data_out)); end
    tick();
    n_checks++; if (psum_data_out !== 32'd28) begin n_fail++; $display("FAIL dbuf_after_swap got %0d want 28", $signed(psum_data_out)); end
    w_load_in = 1; w_swap_in = 1; w_data_in = 8'd9; tick();
    w_load_in = 0; w_swap_in = 0;
    n_checks++; if (w_data_out !== 8'd9) begin n_fail++; $display("FAIL dbuf_load_swap_shadow got %0d want 9", w_data_out); end
    tick();
    n_checks++; if (psum_data_out !== 32'd28) begin n_fail++; $display("FAIL dbuf_load_swap_active got %0d want 28", $signed(psum_data_out)); end
    w_swap_in = 1; tick();
    w_swap_in = 0; tick();
    n_checks++; if (psum_data_out !== 32'd36) begin n_fail++; $display("FAIL dbuf_second_swap got %0d want 36", $signed(psum_data_out)); end
    clear_inputs();
  endtask

  task automatic test_acc_drain();
    do_reset();
    mode_in = 1; tick();
    load_weight(-8'sd2);
    ifmap_valid_in = 1; ifmap_data_in = 16'd1; tick();
    ifmap_data_in = 16'd2; tick();
    ifmap_data_in = 16'd3; tick();
    n_checks++; if (psum_valid_out !== 1'b0) begin n_fail++; $display("FAIL acc_no_early_out got %0b want 0", psum_valid_out); end
    ifmap_valid_in = 0; drain_in = 1; tick();
    n_checks++; if (psum_data_out !== 32'(-12) || psum_valid_out !== 1'b1) begin n_fail++; $display("FAIL acc_drain1 got %0d/%0b want -12/1", $signed(psum_data_out), psum_valid_out); end
    drain_in = 0; tick();
    n_checks++; if (psum_valid_out !== 1'b0) begin n_fail++; $display("FAIL acc_drain_pulse got %0b want 0", psum_valid_out); end
    ifmap_valid_in = 1; ifmap_data_in = 16'd10; tick();
    ifmap_valid_in = 0; tick();
    drain_in = 1; tick();
    drain_in = 0;
    n_checks++; if (psum_data_out !== 32'(-20) || psum_valid_out !== 1'b1) begin n_fail++; $display("FAIL acc_drain2 got %0d/%0b want -20/1", $signed(psum_data_out), psum_valid_out); end
  endtask

  task automatic test_collision();
    ifmap_valid_in = 1; ifmap_data_in = 16'd5; tick();
    ifmap_valid_in = 0; tick();
    n_checks++; if (collision_flag !== 1'b0) begin n_fail++; $display("FAIL coll_flag_before got %0b want 0", collision_flag); end
    drain_in = 1; psum_valid_in = 1; psum_data_in = 32'd55; tick();
    drain_in = 0;
    n_checks++; if (psum_data_out !== 32'(-10) || psum_valid_out !== 1'b1) begin n_fail++; $display("FAIL coll_local_wins got %0d/%0b want -10/1", $signed(psum_data_out), psum_valid_out); end
    n_checks++; if (collision_flag !== 1'b1) begin n_fail++; $display("FAIL coll_flag got %0b want 1", collision_flag); end
    tick();
    n_checks++; if (psum_data_out !== 32'd55 || psum_valid_out !== 1'b1) begin n_fail++; $display("FAIL coll_forward got %0d/%0b want 55/1", $signed(psum_data_out), psum_valid_out); end
    psum_valid_in = 0; tick();
    n_checks++; if (psum_valid_out !== 1'b0 || collision_flag !== 1'b1) begin n_fail++; $display("FAIL coll_after got %0b/%0b want 0/1", psum_valid_out, collision_flag); end
  endtask

  task automatic test_reset_mid();
    ifmap_valid_in = 1; ifmap_data_in = 16'd9; psum_valid_in = 1; psum_data_in = 32'd77;
    tick();
    rst = 1; tick(); tick();
    test_reset();
    rst = 0; clear_inputs(); mode_in = 0; tick();
  endtask

  task automatic test_saturation_acc();
    do_reset();
    mode_in = 1; tick();
    load_weight(8'd127);
    ifmap_valid_in = 1; ifmap_data_in = 16'd32767;
    repeat (517) tick();
    n_checks++; if (sat_flag !== 1'b0 || sat_flag_w !== 1'b0) begin n_fail++; $display("FAIL sat_acc_pre got %0b/%0b want 0/0", sat_flag, sat_flag_w); end
    ifmap_valid_in = 0; drain_in = 1; tick();
    drain_in = 0;
    n_checks++; if (psum_data_out !== 32'd2147483647 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_acc_clamp got %0d/%0b want 2147483647/1", $signed(psum_data_out), sat_flag); end
    n_checks++; if (psum_data_out_w !== 32'(-2143518843) || sat_flag_w !== 1'b1) begin n_fail++; $display("FAIL sat_acc_wrap got %0d/%0b want -2143518843/1", $signed(psum_data_out_w), sat_flag_w); end
  endtask

  task automatic test_saturation_sys();
    do_reset();
    load_weight(8'h80);
    ifmap_valid_in = 1; ifmap_data_in = 16'd32767; tick();
    ifmap_valid_in = 0; psum_valid_in = 1; psum_data_in = 32'h8000_0000; tick();
    psum_valid_in = 0;
    n_checks++; if (psum_data_out !== 32'h8000_0000 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_sys_clamp got %0h/%0b want 80000000/1", psum_data_out, sat_flag); end
    n_checks++; if (psum_data_out_w !== 32'h7FC0_0080 || sat_flag_w !== 1'b1) begin n_fail++; $display("FAIL sat_sys_wrap got %0h/%0b want 7fc00080/1", psum_data_out_w, sat_flag_w); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_sys_mac();
    test_double_buffer();
    test_acc_drain();
    test_collision();
    test_reset_mid();
    test_saturation_acc();
    test_saturation_sys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
